// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - run-control sequencer for the 5-phase one-hot CPU phase ring
//
// Purpose:
//   Starts, stalls, halts and single-steps the P1..P5 phase ring at instruction
//   granularity. It pulses retire once per completed instruction and keeps a
//   wrapping retired-instruction count. Every output comes straight from a flop.
//
// Optional feature macro: PHASE_SKIP_EN
//   Defined   : skip=1 in an unstalled P3 jumps straight to P5, bypassing P4.
//   Undefined : skip is accepted but has no effect.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   start        in   run request; honoured only in IDLE/HALT
//   halt_req     in   halt at the next instruction boundary (sticky)
//   step_mode    in   halt after every instruction (sampled at the boundary)
//   stall        in   hold the current phase this cycle
//   skip         in   skip P4 (PHASE_SKIP_EN builds only)
//   phase        out  one-hot current phase, 00000 when not running
//   busy         out  high while running
//   halted       out  high in HALT
//   retire       out  one-cycle pulse per completed instruction
//   instr_count  out  retired-instruction count, CNT_W bits, wraps

module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             stall,
  input  logic             skip,
  output logic [4:0]       phase,
  output logic             busy,
  output logic             halted,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P1     = 5'b00001;
  localparam logic [4:0] P3     = 5'b00100;
  localparam logic [4:0] P5     = 5'b10000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [4:0]       r_phase;
  logic             r_busy;
  logic             r_halted;
  logic             r_retire;
  logic [CNT_W-1:0] r_count;
  logic             r_halt_pending;

  logic             w_advance;
  logic             w_boundary;
  logic             w_pending;
  logic             w_stop;
  logic             w_skip;
  logic [4:0]       w_next_phase;

  // The ring only moves on unstalled RUN cycles. An unstalled P5 is the
  // instruction boundary, where retire, count and the halt decision happen.
  assign w_advance  = (r_state == S_RUN) && !stall;
  assign w_boundary = w_advance && (r_phase == P5);

  // A halt request in the boundary cycle itself still counts for that boundary.
  assign w_pending  = r_halt_pending | halt_req;
  assign w_stop     = w_boundary && (w_pending || step_mode);

`ifdef PHASE_SKIP_EN
  assign w_skip = (r_phase == P3) && skip;
`else
  // skip stays on the port list for pin compatibility but never acts.
  assign w_skip = 1'b0 & skip;
`endif

  always_comb begin
    w_next_phase = {r_phase[3:0], r_phase[4]};
    if (w_boundary) begin
      w_next_phase = P1;
    end else if (w_skip) begin
      w_next_phase = P5;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_phase        <= P_NONE;
      r_busy         <= 1'b0;
      r_halted       <= 1'b0;
      r_retire       <= 1'b0;
      r_count        <= '0;
      r_halt_pending <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          // halt_req is deliberately ignored while stopped.
          if (start) begin
            r_state  <= S_RUN;
            r_phase  <= P1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_boundary) begin
            r_retire <= 1'b1;
            r_count  <= r_count + CNT_ONE;
          end
          if (w_stop) begin
            r_state        <= S_HALT;
            r_phase        <= P_NONE;
            r_busy         <= 1'b0;
            r_halted       <= 1'b1;
            r_halt_pending <= 1'b0;
          end else begin
            // Captured even while stalled so a single-cycle pulse is never lost.
            r_halt_pending <= w_pending;
            if (w_advance) begin
              r_phase <= w_next_phase;
            end
          end
        end
        default: begin
          // Unreachable encoding; only reset recovers it.
        end
      endcase
    end
  end

  assign phase       = r_phase;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign retire      = r_retire;
  assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
//
// Purpose:
//   Drives two DUTs (CNT_W=16 and CNT_W=4) with the same directed and random
//   stimulus. It compares every output each cycle against a behavioural model
//   built on a phase index, and checks a few latencies as explicit constants.
//
// Optional feature macro: PHASE_SKIP_EN (the model follows the same define).

module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        step_mode;
  logic        stall;
  logic        skip;

  logic [4:0]  phase;
  logic        busy;
  logic        halted;
  logic        retire;
  logic [15:0] instr_count;

  logic [4:0]  phase4;
  logic        busy4;
  logic        halted4;
  logic        retire4;
  logic [3:0]  instr_count4;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

`ifdef PHASE_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  // m_pos: -1 when not running, else 0..4 for P1..P5.
  int m_pos;
  bit m_halted;
  bit m_pending;
  bit m_retire;
  int m_count;

  always #5 clk = ~clk;

  phase_sequencer #(.CNT_W(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .step_mode   (step_mode),
    .stall       (stall),
    .skip        (skip),
    .phase       (phase),
    .busy        (busy),
    .halted      (halted),
    .retire      (retire),
    .instr_count (instr_count)
  );

  phase_sequencer #(.CNT_W(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .step_mode   (step_mode),
    .stall       (stall),
    .skip        (skip),
    .phase       (phase4),
    .busy        (busy4),
    .halted      (halted4),
    .retire      (retire4),
    .instr_count (instr_count4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos     = -1;
    m_halted  = 1'b0;
    m_pending = 1'b0;
    m_retire  = 1'b0;
    m_count   = 0;
  endtask

  task automatic model_step(input bit st, input bit hr, input bit sm, input bit sl, input bit sk);
    m_retire = 1'b0;
    if (m_pos < 0) begin
      if (st) begin
        m_pos    = 0;
        m_halted = 1'b0;
      end
    end else begin
      if (hr) m_pending = 1'b1;
      if (!sl) begin
        if (m_pos == 4) begin
          m_retire = 1'b1;
          m_count  = m_count + 1;
          if (m_pending || sm) begin
            m_pos     = -1;
            m_halted  = 1'b1;
            m_pending = 1'b0;
          end else begin
            m_pos = 0;
          end
        end else if (SKIP_EN && sk && m_pos == 2) begin
          m_pos = 4;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    logic [15:0] exp_phase;
    exp_phase = (m_pos < 0) ? 16'd0 : 16'(1 << m_pos);
    chk({where, ".phase"},   16'(phase),        exp_phase);
    chk({where, ".busy"},    16'(busy),         16'(m_pos >= 0));
    chk({where, ".halted"},  16'(halted),       16'(m_halted));
    chk({where, ".retire"},  16'(retire),       16'(m_retire));
    chk({where, ".count"},   instr_count,       16'(m_count % 65536));
    chk({where, ".phase4"},  16'(phase4),       exp_phase);
    chk({where, ".retire4"}, 16'(retire4),      16'(m_retire));
    chk({where, ".count4"},  16'(instr_count4), 16'(m_count % 16));
  endtask

  task automatic cyc(input bit st, input bit hr, input bit sm, input bit sl, input bit sk);
    @(negedge clk);
    start     = st;
    halt_req  = hr;
    step_mode = sm;
    stall     = sl;
    skip      = sk;
    model_step(st, hr, sm, sl, sk);
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  // Reset is raised between clock edges so the outputs are checked asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    start     = 1'b0;
    halt_req  = 1'b0;
    step_mode = 1'b0;
    stall     = 1'b0;
    skip      = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 12 && !m_halted; i++) cyc(0, 0, 0, 0, 0);
    chk("halt_reached", 16'(halted), 16'd1);
  endtask

  initial begin
    int lat;
    int nret;
    rst       = 1'b0;
    start     = 1'b0;
    halt_req  = 1'b0;
    step_mode = 1'b0;
    stall     = 1'b0;
    skip      = 1'b0;
    model_reset();

    do_reset();

    // Plain run: P1..P5 then P1 with retire, into the second instruction.
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);

    // Now in P2: one-cycle halt pulse, instruction completes then halts.
    cyc(0, 1, 0, 0, 0);
    run_to_halt();

    // Resume; stall 3 cycles in P2 with a halt request captured under stall.
    cyc(1, 0, 0, 0, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, i == 2, 0, (i >= 2 && i <= 4), 0);
      lat = i;
      if (retire) break;
    end
    chk("stall_latency", 16'(lat), 16'd8);
    chk("stall_then_halt", 16'(halted), 16'd1);

    // Single-step: three starts, each ends in HALT. The last one raises
    // step_mode only in the boundary cycle.
    nret = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
        cyc(0, 0, (k == 2) ? (m_pos == 4) : 1'b1, 0, 0);
        if (retire) nret++;
        if (m_halted) break;
      end
    end
    chk("step_retires", 16'(nret), 16'd3);

    // Unstalled latency, then 16 back-to-back instructions to wrap the 4-bit counter.
    cyc(1, 0, 0, 0, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0, 0, 0);
      lat = i;
      if (retire) break;
    end
    chk("run_latency", 16'(lat), 16'd5);
    repeat (16 * 5) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    run_to_halt();

    // Skip requested in P3 (shortens when enabled), then in P2 (never acts).
    cyc(1, 0, 0, 0, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0, 0, m_pos == 2);
      lat = i;
      if (retire) break;
    end
    chk("skip_p3_latency", 16'(lat), SKIP_EN ? 16'd4 : 16'd5);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0, 0, m_pos == 1);
      lat = i;
      if (retire) break;
    end
    chk("skip_p2_latency", 16'(lat), 16'd5);
    cyc(0, 1, 0, 0, 0);
    run_to_halt();

    // Random traffic with a reset dropped in mid-stream.
    for (int it = 0; it < 600; it++) begin
      if (it == 300) do_reset();
      cyc(($urandom % 8) == 0, ($urandom % 20) == 0, ($urandom % 4) == 0,
          ($urandom % 4) == 0, ($urandom % 2) == 0);
    end

    // Reset landing mid-instruction: no retire, count cleared.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
